clarke_rr_scheduler: RTL
========================

CLARKE_RR_SCHEDULER -- requirements
Module: clarke_rr_scheduler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 10, sample width in signed two's complement.
REQ-002 SHALL have parameter N_CH, default 4, number of requesting channels (2..8).
REQ-003 SHALL have port clk_i, input, 1, the single clock; all logic rising-edge.
REQ-004 SHALL have port rst_i, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have port cfg_ch_en_i, input, N_CH, per-channel enable mask.
REQ-006 SHALL have port s_valid_i, input, N_CH, per-channel request valid.
REQ-007 SHALL have port s_ready_o, output, N_CH, per-channel grant/ready; at most one bit high.
REQ-008 SHALL have ports s_a_i and s_b_i, input, N_CH x DATA_WIDTH signed, per-channel phase a/b samples.
REQ-009 SHALL have port m_valid_o, output, 1, result valid.
REQ-010 SHALL have port m_ready_i, input, 1, downstream ready.
REQ-011 SHALL have port m_ch_o, output, clog2(N_CH), channel tag of the result.
REQ-012 SHALL have ports m_al_o and m_be_o, output, DATA_WIDTH signed, alpha/beta result.
REQ-013 SHALL have port busy_o, output, 1, high while any transaction is in flight or buffered.

Function
REQ-014 SHALL share one forward Clarke datapath (al = a; be = (a+2b)*K >> (DATA_WIDTH-1), K = trunc(0.577350269*(2^(DATA_WIDTH-1)-1))) among N_CH channels.
REQ-015 SHALL count an input transfer on channel k when s_valid_i[k] & s_ready_o[k] in the same cycle.
REQ-016 SHALL assert s_ready_o[k] only if cfg_ch_en_i[k], s_valid_i[k], credit available, and k wins round-robin; s_ready_o may depend combinationally on s_valid_i.
REQ-017 SHALL use round-robin priority: search starts at pointer p; after a grant to k, p <= (k+1) mod N_CH; p unchanged when no grant.
REQ-018 SHALL register the selected a/b, a valid bit and a channel tag at the grant edge (datapath stage 1), computing al/be from stage-1 registers.
REQ-019 SHALL push the stage-1 result plus tag into a 2-entry output FIFO at the following edge when the stage-1 valid bit is set.
REQ-020 SHALL drive m_valid_o/m_ch_o/m_al_o/m_be_o from the FIFO head; pop on m_valid_o & m_ready_i.
REQ-021 SHALL have latency of exactly 2 cycles, handshake cycle T to m_valid_o at T+2, when the FIFO is empty.
REQ-022 SHALL grant only when (stage-1 valid + FIFO count - pop this cycle) < 2; no result is ever dropped.
REQ-023 SHALL hold m_* outputs stable while m_valid_o & !m_ready_i.
REQ-024 SHALL deliver results in grant order; full throughput is one result per cycle with m_ready_i held high.
REQ-025 SHALL, on simultaneous FIFO push and pop, keep the count unchanged; push into a full FIFO is impossible by REQ-022.
REQ-026 SHALL ignore channels with cfg_ch_en_i low; clearing a bit never cancels in-flight results.
REQ-027 SHALL pass datapath arithmetic bit-exact, with no saturation; be wraps per the DATA_WIDTH truncation.
REQ-028 SHALL assert busy_o = stage-1 valid | FIFO non-empty.

Reset
REQ-029 SHALL on rst_i clear s_ready_o, m_valid_o, busy_o, m_ch_o, m_al_o and m_be_o to 0, set p to 0, and empty the FIFO and stage-1 valid.
REQ-030 SHALL, on reset mid-operation, discard all in-flight and buffered results, with m_valid_o low from the cycle after rst_i is sampled.
REQ-031 SHALL issue no grant in any cycle where rst_i is high.

Structure
REQ-032 SHALL place DATA_WIDTH/N_CH defaults, channel-index typedef, K constant function and result struct (ch, al, be) in shared package clarke_pkg.
REQ-033 SHALL implement arbitration in one sub-module rr_arbiter (request vector, enable, pointer -> one-hot grant, index).
REQ-034 SHALL keep the datapath, FIFO and credit logic in clarke_rr_scheduler.

Verification (DATA_WIDTH=10, N_CH=4, K=295)
REQ-035 SHALL cover: ch1 a=100 b=50, m_ready_i=1 -> m_valid_o at T+2, m_ch_o=1, al=100, be=115.
REQ-036 SHALL cover: ch2 a=-100 b=-50 -> al=-100, be=-116.
REQ-037 SHALL cover: all 4 channels valid continuously, all enabled -> grants 0,1,2,3,0,... one per cycle, results in the same order.
REQ-038 SHALL cover: m_ready_i=0 with continuous requests -> exactly 2 grants, then s_ready_o=0; outputs stable; after release, results 1 and 2 drain in order.
REQ-039 SHALL cover: cfg_ch_en_i=4'b1010 with all valid -> only channels 1 and 3 are granted, alternating.
REQ-040 SHALL cover: rst_i pulsed with 2 results buffered -> m_valid_o=0 and busy_o=0 next cycle; the next grant goes to ch0 when it is valid.

Source files
------------

// File: rtl/clarke_pkg.sv
// Shared constants, types and the Clarke scaling constant for the
// time-shared alpha/beta transform scheduler.
package clarke_pkg;

    localparam int DATA_WIDTH_DEF = 10;
    localparam int N_CH_DEF       = 4;
    localparam int CH_W_DEF       = $clog2(N_CH_DEF);

    typedef logic [CH_W_DEF-1:0] ch_idx_t;

    typedef struct packed {
        ch_idx_t                     ch;
        logic signed [DATA_WIDTH_DEF-1:0] al;
        logic signed [DATA_WIDTH_DEF-1:0] be;
    } clarke_result_t;

    // K = trunc(0.577350269 * (2^(dw-1) - 1)), in integer math so it folds at elaboration
    function automatic int clarke_k(input int dw);
        longint full_scale;
        full_scale = (longint'(1) <<< (dw - 1)) - longint'(1);
        return int'((full_scale * longint'(577350269)) / longint'(1000000000));
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first enabled requester at or after the
// pointer and returns it as a one-hot grant plus a binary index.
module rr_arbiter #(
    parameter int N_CH = 4,
    localparam int CW = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] req_i,
    input  logic [N_CH-1:0] en_i,
    input  logic [CW-1:0]   ptr_i,
    output logic [N_CH-1:0] grant_o,
    output logic [CW-1:0]   idx_o,
    output logic            valid_o
);

    localparam logic [CW:0] NCH_V = (CW+1)'(N_CH);

    logic [CW:0]   pos;
    logic [CW-1:0] cand;

    // The extra bit on pos lets the wrap work for non-power-of-two channel counts
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        pos     = '0;
        cand    = '0;
        for (int i = 0; i < N_CH; i++) begin
            pos = {1'b0, ptr_i} + (CW+1)'(i);
            if (pos >= NCH_V) begin
                pos = pos - NCH_V;
            end
            cand = pos[CW-1:0];
            if (!valid_o && req_i[cand] && en_i[cand]) begin
                grant_o[cand] = 1'b1;
                idx_o         = cand;
                valid_o       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/clarke_rr_scheduler.sv
// N_CH requesters share one forward Clarke datapath: round-robin grant,
// one register stage, then a 2-entry output FIFO guarded by credits.
module clarke_rr_scheduler
    import clarke_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int N_CH       = N_CH_DEF,
    localparam int CW        = $clog2(N_CH)
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [N_CH-1:0]                     cfg_ch_en_i,
    input  logic [N_CH-1:0]                     s_valid_i,
    output logic [N_CH-1:0]                     s_ready_o,
    input  logic [N_CH-1:0][DATA_WIDTH-1:0]     s_a_i,
    input  logic [N_CH-1:0][DATA_WIDTH-1:0]     s_b_i,
    output logic                                m_valid_o,
    input  logic                                m_ready_i,
    output logic [CW-1:0]                       m_ch_o,
    output logic signed [DATA_WIDTH-1:0]        m_al_o,
    output logic signed [DATA_WIDTH-1:0]        m_be_o,
    output logic                                busy_o
);

    localparam int                     PW      = 2*DATA_WIDTH - 1;
    localparam logic signed [PW-1:0]   K_P     = PW'(clarke_k(DATA_WIDTH));
    localparam logic [CW-1:0]          LAST_CH = CW'(N_CH - 1);

    typedef struct packed {
        logic [CW-1:0]                 ch;
        logic signed [DATA_WIDTH-1:0]  al;
        logic signed [DATA_WIDTH-1:0]  be;
    } entry_t;

    logic [CW-1:0]                ptr_q, ptr_d;
    logic                         s1_valid_q, s1_valid_d;
    logic signed [DATA_WIDTH-1:0] s1_a_q, s1_a_d;
    logic signed [DATA_WIDTH-1:0] s1_b_q, s1_b_d;
    logic [CW-1:0]                s1_ch_q, s1_ch_d;
    entry_t                       fifo_q [2];
    entry_t                       fifo_d [2];
    logic                         wr_q, wr_d;
    logic                         rd_q, rd_d;
    logic [1:0]                   count_q, count_d;

    logic                         pop;
    logic [1:0]                   occupancy;
    logic                         can_grant;
    logic [N_CH-1:0]              arb_req;
    logic [N_CH-1:0]              arb_grant;
    logic [CW-1:0]                arb_idx;
    logic                         arb_valid;
    logic signed [PW-1:0]         sum_w;
    logic signed [PW-1:0]         prod_w;
    logic signed [DATA_WIDTH-1:0] be_w;
    entry_t                       head;

    // A new grant needs a free slot counting stage 1 and the FIFO, net of this cycle's pop
    assign pop       = m_valid_o & m_ready_i;
    assign occupancy = count_q + {1'b0, s1_valid_q} - {1'b0, pop};
    assign can_grant = !rst_i && (occupancy < 2'd2);
    assign arb_req   = s_valid_i & {N_CH{can_grant}};

    rr_arbiter #(
        .N_CH (N_CH)
    ) u_arb (
        .req_i   (arb_req),
        .en_i    (cfg_ch_en_i),
        .ptr_i   (ptr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    assign s_ready_o = arb_grant;

    // Products are kept modulo 2^PW; bits above that never reach the truncated beta
    assign sum_w  = PW'(s1_a_q) + (PW'(s1_b_q) <<< 1);
    assign prod_w = sum_w * K_P;
    assign be_w   = DATA_WIDTH'(prod_w >>> (DATA_WIDTH - 1));

    always_comb begin
        ptr_d      = ptr_q;
        s1_valid_d = arb_valid;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_ch_d    = s1_ch_q;
        if (arb_valid) begin
            s1_a_d  = s_a_i[arb_idx];
            s1_b_d  = s_b_i[arb_idx];
            s1_ch_d = arb_idx;
            ptr_d   = (arb_idx == LAST_CH) ? '0 : arb_idx + CW'(1);
        end
    end

    always_comb begin
        fifo_d  = fifo_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (s1_valid_q) begin
            fifo_d[wr_q] = '{ch: s1_ch_q, al: s1_a_q, be: be_w};
            wr_d         = ~wr_q;
        end
        if (pop) begin
            rd_d = ~rd_q;
        end
        case ({s1_valid_q, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_ch_q    <= '0;
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            ptr_q      <= ptr_d;
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_ch_q    <= s1_ch_d;
            fifo_q[0]  <= fifo_d[0];
            fifo_q[1]  <= fifo_d[1];
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            count_q    <= count_d;
        end
    end

    assign head      = fifo_q[rd_q];
    assign m_valid_o = (count_q != 2'd0);
    assign m_ch_o    = head.ch;
    assign m_al_o    = head.al;
    assign m_be_o    = head.be;
    assign busy_o    = s1_valid_q | m_valid_o;

endmodule
